// File: rtl/adc_xy_fb_writer.sv
// Clips ADC X/Y samples to the visible raster, converts them to linear framebuffer
// addresses, suppresses repeats and queues pixel writes behind a valid/ready FIFO.
module adc_xy_fb_writer #(
    parameter int                    ADC_DATA_BITS = 10,
    parameter int                    H_VISIBLE     = 640,
    parameter int                    V_VISIBLE     = 480,
    parameter int                    ADDR_BITS     = 20,
    parameter int                    PIXEL_BITS    = 12,
    parameter int                    META_BITS     = 4,
    parameter logic [PIXEL_BITS-1:0] PIXEL_COLOR   = 12'hFFF,
    parameter logic [META_BITS-1:0]  PIXEL_META    = 4'h0,
    parameter int                    FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            adc_valid,
    input  logic [ADC_DATA_BITS-1:0]        adc_x,
    input  logic [ADC_DATA_BITS-1:0]        adc_y,
    output logic                            fb_wr_valid,
    input  logic                            fb_wr_ready,
    output logic [ADDR_BITS-1:0]            fb_wr_addr,
    output logic [META_BITS+PIXEL_BITS-1:0] fb_wr_data,
    input  logic                            clear_stats,
    output logic [15:0]                     drop_clip,
    output logic [15:0]                     drop_dup,
    output logic [15:0]                     drop_ovf
);

    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int PROD_BITS = ADC_DATA_BITS + 33;

    if (longint'(H_VISIBLE) * longint'(V_VISIBLE) > (longint'(1) << ADDR_BITS)) begin : g_bad_raster
        $error("adc_xy_fb_writer: H_VISIBLE*V_VISIBLE does not fit in ADDR_BITS");
    end
    if (FIFO_DEPTH < 2 || (1 << PTR_BITS) != FIFO_DEPTH) begin : g_bad_depth
        $error("adc_xy_fb_writer: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                     in_range;
    logic                     clip_hit;
    logic                     s1_vld, s2_vld;
    logic [ADC_DATA_BITS-1:0] s1_x, s1_y;
    logic [ADDR_BITS-1:0]     s2_addr;
    logic                     last_vld;
    logic [ADDR_BITS-1:0]     last_addr;
    logic                     do_push, do_pop, do_dup, do_ovf;

    logic [ADDR_BITS-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]      wr_ptr, rd_ptr;
    logic [PTR_BITS:0]        count;
    logic                     fifo_full, fifo_empty;

    assign in_range = (32'(adc_x) < H_VISIBLE) && (32'(adc_y) < V_VISIBLE);
    assign clip_hit = adc_valid && !in_range;

    // S1 / S2 valid flags carry the reset; the data beside them only matters when valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= adc_valid && in_range;
            s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (adc_valid) begin
            s1_x <= adc_x;
            s1_y <= adc_y;
        end
        if (s1_vld) begin
            s2_addr <= ADDR_BITS'(PROD_BITS'(s1_y) * PROD_BITS'(H_VISIBLE) + PROD_BITS'(s1_x));
        end
    end

    assign fifo_full  = (count == (PTR_BITS+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign do_pop     = !fifo_empty && fb_wr_ready;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        do_dup  = 1'b0;
        do_ovf  = 1'b0;
        do_push = 1'b0;
        if (s2_vld) begin
            if (last_vld && s2_addr == last_addr) begin
                do_dup = 1'b1;
            end else if (fifo_full && !do_pop) begin
                do_ovf = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_vld <= 1'b0;
        end else if (do_push) begin
            last_vld <= 1'b1;
        end
        if (do_push) begin
            last_addr <= s2_addr;
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= s2_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_BITS+1)'(1);
                2'b01:   count <= count - (PTR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign fb_wr_valid = !fifo_empty;
    assign fb_wr_addr  = fb_wr_valid ? fifo_mem[rd_ptr] : '0;
    assign fb_wr_data  = fb_wr_valid ? {PIXEL_META, PIXEL_COLOR} : '0;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
        return (inc && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

    // Clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            drop_clip <= '0;
            drop_dup  <= '0;
            drop_ovf  <= '0;
        end else begin
            drop_clip <= sat_inc(drop_clip, clip_hit);
            drop_dup  <= sat_inc(drop_dup, do_dup);
            drop_ovf  <= sat_inc(drop_ovf, do_ovf);
        end
    end

endmodule
